// File: rtl/clip_record_controller.sv
// Record/playback sequencer for NUM_CLIPS clips of CLIP_SAMPLES samples each.
// Define LOOP_PLAY_EN to make playback loop until aborted or stopped by a new play_req.
module clip_record_controller #(
  parameter int NUM_CLIPS    = 4,
  parameter int CLIP_SAMPLES = 16000,
  parameter int CLIP_W       = $clog2(NUM_CLIPS),
  parameter int SAMP_W       = $clog2(CLIP_SAMPLES),
  parameter int ADDR_W       = CLIP_W + SAMP_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 record_req,
  input  logic                 play_req,
  input  logic                 abort,
  input  logic [CLIP_W-1:0]    clip_sel,
  input  logic                 sample_tick,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic                 deseriena,
  output logic                 seriena,
  output logic                 busy,
  output logic                 done,
  output logic                 play_err,
  output logic [NUM_CLIPS-1:0] clip_valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RECORD = 2'd1;
  localparam logic [1:0] PLAY   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [SAMP_W-1:0] LAST_IDX = SAMP_W'(CLIP_SAMPLES - 1);

  logic [1:0]        state;
  logic [SAMP_W-1:0] counter;
  logic [CLIP_W-1:0] clip;

  // Every output is registered and computed for the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      counter    <= '0;
      clip       <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      deseriena  <= 1'b0;
      seriena    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      play_err   <= 1'b0;
      clip_valid <= '0;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      done     <= 1'b0;
      play_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!abort) begin
            if (record_req) begin
              clip                 <= clip_sel;
              counter              <= '0;
              clip_valid[clip_sel] <= 1'b0;
              state                <= RECORD;
              deseriena            <= 1'b1;
              busy                 <= 1'b1;
            end else if (play_req) begin
              if (clip_valid[clip_sel]) begin
                clip    <= clip_sel;
                counter <= '0;
                state   <= PLAY;
                seriena <= 1'b1;
                busy    <= 1'b1;
              end else begin
                play_err <= 1'b1;
              end
            end
          end
        end
        RECORD: begin
          if (abort) begin
            state     <= IDLE;
            deseriena <= 1'b0;
            busy      <= 1'b0;
          end else if (sample_tick) begin
            mem_we   <= 1'b1;
            mem_addr <= {clip, counter};
            if (counter == LAST_IDX) begin
              clip_valid[clip] <= 1'b1;
              state            <= FINISH;
              deseriena        <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        PLAY: begin
          if (abort) begin
            state   <= IDLE;
            seriena <= 1'b0;
            busy    <= 1'b0;
`ifdef LOOP_PLAY_EN
          end else if (play_req) begin
            state   <= FINISH;
            seriena <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
`endif
          end else if (sample_tick) begin
            mem_re   <= 1'b1;
            mem_addr <= {clip, counter};
            if (counter == LAST_IDX) begin
`ifdef LOOP_PLAY_EN
              counter <= '0;
`else
              state   <= FINISH;
              seriena <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
